pipe_ctrl: RTL and testbench

- Pipelined successor to the single-cycle RV32I control decoder.
- Decodes the full RV32I base set in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and, when forwarding is disabled, RAW hazards; generates forwarding selects.
- Resolves branches and jumps in EX and issues the stall/flush controls for the PC and IF/ID registers.

---
 rtl/pipe_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipelined RV32I control: ID decode, ID/EX-EX/MEM-MEM/WB control bundle, hazards, forwarding,
// and EX branch resolution. Define PIPE_CTRL_MULDIV_EN to also decode RV32M.
module pipe_ctrl #(
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned EXTOP_W = 6,
  parameter int unsigned NPCOP_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        id_instr,
  input  logic               id_valid,
  input  logic               ex_zero,
  input  logic               ex_lt,
  input  logic               ex_ltu,
  output logic [EXTOP_W-1:0] id_ext_op,
  output logic               stall,
  output logic               flush,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [NPCOP_W-1:0] ex_npc_op,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_write,
  output logic               mem_read,
  output logic [2:0]         mem_funct3,
  output logic               wb_reg_write,
  output logic [1:0]         wb_wd_sel,
  output logic [4:0]         wb_rd
);

  localparam logic [ALUOP_W-1:0] AluNop   = ALUOP_W'(5'b00000);
  localparam logic [ALUOP_W-1:0] AluLui   = ALUOP_W'(5'b00001);
  localparam logic [ALUOP_W-1:0] AluAuipc = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(5'b00011);
  localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(5'b00100);
  localparam logic [ALUOP_W-1:0] AluSlt   = ALUOP_W'(5'b01010);
  localparam logic [ALUOP_W-1:0] AluSltu  = ALUOP_W'(5'b01011);
  localparam logic [ALUOP_W-1:0] AluXor   = ALUOP_W'(5'b01100);
  localparam logic [ALUOP_W-1:0] AluOr    = ALUOP_W'(5'b01101);
  localparam logic [ALUOP_W-1:0] AluAnd   = ALUOP_W'(5'b01110);
  localparam logic [ALUOP_W-1:0] AluSll   = ALUOP_W'(5'b01111);
  localparam logic [ALUOP_W-1:0] AluSrl   = ALUOP_W'(5'b10000);
  localparam logic [ALUOP_W-1:0] AluSra   = ALUOP_W'(5'b10001);

  localparam logic [EXTOP_W-1:0] ExtIShamt = EXTOP_W'(6'b100000);
  localparam logic [EXTOP_W-1:0] ExtI      = EXTOP_W'(6'b010000);
  localparam logic [EXTOP_W-1:0] ExtS      = EXTOP_W'(6'b001000);
  localparam logic [EXTOP_W-1:0] ExtB      = EXTOP_W'(6'b000100);
  localparam logic [EXTOP_W-1:0] ExtU      = EXTOP_W'(6'b000010);
  localparam logic [EXTOP_W-1:0] ExtJ      = EXTOP_W'(6'b000001);

  localparam logic [NPCOP_W-1:0] NpcPlus4  = NPCOP_W'(5'b00000);
  localparam logic [NPCOP_W-1:0] NpcBranch = NPCOP_W'(5'b00001);
  localparam logic [NPCOP_W-1:0] NpcJump   = NPCOP_W'(5'b00010);
  localparam logic [NPCOP_W-1:0] NpcJalr   = NPCOP_W'(5'b00100);

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  // All-zero encodes a bubble in every stage register.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               is_branch;
    logic               is_jal;
    logic               is_jalr;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         funct3;
    logic               reg_write;
    logic [1:0]         wd_sel;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic               rs1_used;
    logic               rs2_used;
  } id_ex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
    logic [1:0] wd_sel;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wd_sel;
    logic [4:0] rd;
  } mem_wb_t;

  id_ex_t  dec, id_ex_d, ex_q;
  ex_mem_t ex_mem_d, mem_q;
  mem_wb_t mem_wb_d, wb_q;
  logic    legal;
  logic [EXTOP_W-1:0] ext;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7     = id_instr[31:25];

  function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] fn);
    logic [ALUOP_W-1:0] op;
    unique case (fn)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    legal = 1'b0;
    ext   = '0;
    dec   = '0;
    dec.funct3 = f3;
    dec.rs1    = id_instr[19:15];
    dec.rs2    = id_instr[24:20];
    dec.rd     = id_instr[11:7];
    unique case (opcode)
      7'b0110111, 7'b0010111: begin
        legal = 1'b1;
        ext = ExtU;
        dec.alu_op = opcode[5] ? AluLui : AluAuipc;
        dec.alu_src = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b1101111: begin
        legal = 1'b1;
        ext = ExtJ;
        dec.is_jal = 1'b1;
        dec.reg_write = 1'b1;
        dec.wd_sel = WdPc;
      end
      7'b1100111: begin
        legal = (f3 == 3'b000);
        ext = ExtI;
        dec.alu_op = AluAdd;
        dec.alu_src = 1'b1;
        dec.is_jalr = 1'b1;
        dec.reg_write = 1'b1;
        dec.wd_sel = WdPc;
        dec.rs1_used = 1'b1;
      end
      7'b1100011: begin
        legal = (f3[2:1] != 2'b01);
        ext = ExtB;
        dec.alu_op = AluSub;
        dec.is_branch = 1'b1;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      7'b0000011: begin
        legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        ext = ExtI;
        dec.alu_op = AluAdd;
        dec.alu_src = 1'b1;
        dec.mem_read = 1'b1;
        dec.reg_write = 1'b1;
        dec.wd_sel = WdMem;
        dec.rs1_used = 1'b1;
      end
      7'b0100011: begin
        legal = (f3 inside {3'b000, 3'b001, 3'b010});
        ext = ExtS;
        dec.alu_op = AluAdd;
        dec.alu_src = 1'b1;
        dec.mem_write = 1'b1;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      7'b0010011: begin
        dec.alu_src = 1'b1;
        dec.reg_write = 1'b1;
        dec.rs1_used = 1'b1;
        dec.alu_op = base_op(f3);
        if (f3 == 3'b001) begin
          legal = (f7 == 7'b0000000);
          ext = ExtIShamt;
        end else if (f3 == 3'b101) begin
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          ext = ExtIShamt;
          if (f7[5]) dec.alu_op = AluSra;
        end else begin
          legal = 1'b1;
          ext = ExtI;
        end
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          dec.alu_op = base_op(f3);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal = 1'b1;
          dec.alu_op = f3[2] ? AluSra : AluSub;
        end
`ifdef PIPE_CTRL_MULDIV_EN
        else if (f7 == 7'b0000001) begin
          legal = 1'b1;
          dec.alu_op = ALUOP_W'(5'b10010 + {2'b00, f3});
        end
`endif
      end
      default: ;
    endcase
    if (!dec.reg_write) dec.rd = '0;
    if (!dec.rs1_used)  dec.rs1 = '0;
    if (!dec.rs2_used)  dec.rs2 = '0;
  end

  assign id_ext_op = legal ? ext : '0;

  logic   id_ok;
  id_ex_t id_bundle;
  assign id_ok     = id_valid && legal;
  assign id_bundle = id_ok ? dec : '0;

  // Source match of an in-flight writer against the ID instruction's used sources.
  logic ex_hit, mem_hit, load_use, raw_stall;
  assign ex_hit = ex_q.reg_write && (ex_q.rd != 5'd0) &&
                  ((id_bundle.rs1_used && ex_q.rd == id_bundle.rs1) ||
                   (id_bundle.rs2_used && ex_q.rd == id_bundle.rs2));
  assign mem_hit = mem_q.reg_write && (mem_q.rd != 5'd0) &&
                   ((id_bundle.rs1_used && mem_q.rd == id_bundle.rs1) ||
                    (id_bundle.rs2_used && mem_q.rd == id_bundle.rs2));
  assign load_use  = ex_hit && ex_q.mem_read;
  assign raw_stall = (FWD_EN != 0) ? load_use : (ex_hit || mem_hit);

  logic take;
  always_comb begin
    unique case (ex_q.funct3)
      3'b000:  take = ex_zero;
      3'b001:  take = ~ex_zero;
      3'b100:  take = ex_lt;
      3'b101:  take = ~ex_lt;
      3'b110:  take = ex_ltu;
      3'b111:  take = ~ex_ltu;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    if (ex_q.is_jal)                  ex_npc_op = NpcJump;
    else if (ex_q.is_jalr)            ex_npc_op = NpcJalr;
    else if (ex_q.is_branch && take)  ex_npc_op = NpcBranch;
    else                              ex_npc_op = NpcPlus4;
  end

  assign flush = (ex_npc_op != NpcPlus4);
  assign stall = raw_stall && !flush;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (ex_q.rs1_used && mem_q.reg_write && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs1 &&
          !mem_q.mem_read) fwd_a = 2'b10;
      else if (ex_q.rs1_used && wb_q.reg_write && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs1)
        fwd_a = 2'b01;
      if (ex_q.rs2_used && mem_q.reg_write && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs2 &&
          !mem_q.mem_read) fwd_b = 2'b10;
      else if (ex_q.rs2_used && wb_q.reg_write && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs2)
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    id_ex_d = (stall || flush) ? '0 : id_bundle;
    ex_mem_d.mem_read  = ex_q.mem_read;
    ex_mem_d.mem_write = ex_q.mem_write;
    ex_mem_d.funct3    = ex_q.funct3;
    ex_mem_d.reg_write = ex_q.reg_write;
    ex_mem_d.wd_sel    = ex_q.wd_sel;
    ex_mem_d.rd        = ex_q.rd;
    mem_wb_d.reg_write = mem_q.reg_write;
    mem_wb_d.wd_sel    = mem_q.wd_sel;
    mem_wb_d.rd        = mem_q.rd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= id_ex_d;
      mem_q <= ex_mem_d;
      wb_q  <= mem_wb_d;
    end
  end

  assign ex_alu_op    = ex_q.alu_op;
  assign ex_alu_src   = ex_q.alu_src;
  assign mem_write    = mem_q.mem_write;
  assign mem_read     = mem_q.mem_read;
  assign mem_funct3   = mem_q.funct3;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_wd_sel    = wb_q.wd_sel;
  assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding instance and one interlock-only instance share
// the same stimulus; each check targets the instance whose behaviour it exercises.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] id_instr;
  logic        id_valid, ex_zero, ex_lt, ex_ltu;

  logic [5:0] f_ext, i_ext;
  logic       f_stall, i_stall, f_flush, i_flush;
  logic [4:0] f_alu, i_alu, f_npc, i_npc;
  logic       f_src, i_src;
  logic [1:0] f_fa, f_fb, i_fa, i_fb;
  logic       f_mw, f_mr, i_mw, i_mr;
  logic [2:0] f_f3, i_f3;
  logic       f_we, i_we;
  logic [1:0] f_sel, i_sel;
  logic [4:0] f_rd, i_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rstn(rstn), .id_instr(id_instr), .id_valid(id_valid),
    .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .id_ext_op(f_ext), .stall(f_stall), .flush(f_flush), .ex_alu_op(f_alu),
    .ex_alu_src(f_src), .ex_npc_op(f_npc), .fwd_a(f_fa), .fwd_b(f_fb),
    .mem_write(f_mw), .mem_read(f_mr), .mem_funct3(f_f3),
    .wb_reg_write(f_we), .wb_wd_sel(f_sel), .wb_rd(f_rd)
  );

  pipe_ctrl #(.FWD_EN(0)) u_ilk (
    .clk(clk), .rstn(rstn), .id_instr(id_instr), .id_valid(id_valid),
    .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .id_ext_op(i_ext), .stall(i_stall), .flush(i_flush), .ex_alu_op(i_alu),
    .ex_alu_src(i_src), .ex_npc_op(i_npc), .fwd_a(i_fa), .fwd_b(i_fb),
    .mem_write(i_mw), .mem_read(i_mr), .mem_funct3(i_f3),
    .wb_reg_write(i_we), .wb_wd_sel(i_sel), .wb_rd(i_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    id_instr = ins;
    id_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    id_instr = 32'h0;
    id_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rstn = 1'b0; id_instr = 32'h002081B3; id_valid = 1'b1;
    ex_zero = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0;
    repeat (3) tick();
    chk("rst_stall", f_stall, 0);
    chk("rst_flush", f_flush, 0);
    chk("rst_fwd_a", f_fa, 0);
    chk("rst_fwd_b", f_fb, 0);
    chk("rst_npc", f_npc, 0);
    chk("rst_alu", f_alu, 0);
    chk("rst_mem_write", f_mw, 0);
    chk("rst_mem_read", f_mr, 0);
    chk("rst_wb_we", f_we, 0);
    chk("rst_wb_rd", f_rd, 0);
    chk("rst_ilk_stall", i_stall, 0);
    chk("rst_ext_rtype", f_ext, 0);

    // Release: add x3,x1,x2 is captured by the first edge.
    rstn = 1'b1;
    tick();
    chk("rel_ex_alu", f_alu, 5'b00011);
    chk("rel_alu_src", f_src, 0);
    idle();
    tick();
    tick();
    chk("rel_wb_we", f_we, 1);
    chk("rel_wb_rd", f_rd, 3);
    chk("rel_wb_sel", f_sel, 2'b00);

    // Illegal encoding decodes as a pure bubble.
    issue(32'hFFFFFFFF);
    chk("ill_ext", f_ext, 0);
    chk("ill_stall", f_stall, 0);
    tick(); idle();
    chk("ill_alu", f_alu, 0);
    chk("ill_npc", f_npc, 0);
    chk("ill_flush", f_flush, 0);
    chk("ill_src", f_src, 0);
    tick();
    chk("ill_mem_write", f_mw, 0);
    chk("ill_mem_read", f_mr, 0);
    tick();
    chk("ill_wb_we", f_we, 0);
    chk("ill_wb_rd", f_rd, 0);

    // Load-use: lw x5 then add x6,x5,x5.
    issue(32'h0000A283);
    chk("lu_ext", f_ext, 6'b010000);
    tick();
    issue(32'h00528333);
    chk("lu_stall", f_stall, 1);
    chk("lu_ilk_stall", i_stall, 1);
    chk("lu_flush", f_flush, 0);
    tick();
    chk("lu_bubble", f_alu, 0);
    chk("lu_mem_read", f_mr, 1);
    chk("lu_mem_f3", f_f3, 3'b010);
    chk("lu_stall2", f_stall, 0);
    chk("lu_ilk_stall2", i_stall, 1);
    tick();
    chk("lu_fwd_a", f_fa, 2'b01);
    chk("lu_fwd_b", f_fb, 2'b01);
    chk("lu_ex_alu", f_alu, 5'b00011);
    chk("lu_wb_rd", f_rd, 5);
    chk("lu_wb_sel", f_sel, 2'b01);
    chk("lu_ilk_stall3", i_stall, 0);
    drain();

    // EX/MEM forwarding: addi x1 then add x2,x1,x1.
    issue(32'h00500093);
    chk("fw_ext", f_ext, 6'b010000);
    tick();
    issue(32'h00108133);
    chk("fw_stall", f_stall, 0);
    chk("fw_ilk_stall", i_stall, 1);
    tick();
    chk("fw_fwd_a", f_fa, 2'b10);
    chk("fw_fwd_b", f_fb, 2'b10);
    chk("fw_ilk_stall2", i_stall, 1);
    chk("fw_ilk_fwd_a", i_fa, 2'b00);
    tick();
    chk("fw_ilk_stall3", i_stall, 0);
    tick();
    chk("fw_ilk_ex_alu", i_alu, 5'b00011);
    chk("fw_ilk_fwd_b", i_fb, 2'b00);
    drain();

    // x0 is never a hazard nor a forwarding source.
    issue(32'h00500013);
    tick();
    issue(32'h00000133);
    chk("x0_stall", f_stall, 0);
    chk("x0_ilk_stall", i_stall, 0);
    tick();
    chk("x0_fwd_a", f_fa, 2'b00);
    chk("x0_fwd_b", f_fb, 2'b00);
    drain();

    // Taken beq squashes the instruction behind it.
    ex_zero = 1'b1;
    issue(32'h00000463);
    chk("br_ext", f_ext, 6'b000100);
    tick();
    issue(32'h00500093);
    chk("br_npc", f_npc, 5'b00001);
    chk("br_flush", f_flush, 1);
    chk("br_stall", f_stall, 0);
    chk("br_alu", f_alu, 5'b00100);
    tick(); idle();
    chk("br_squash", f_alu, 0);
    chk("br_flush2", f_flush, 0);
    ex_zero = 1'b0;
    issue(32'h00000463);
    tick(); idle();
    chk("bnt_npc", f_npc, 5'b00000);
    chk("bnt_flush", f_flush, 0);
    issue(32'h00005463);
    tick(); idle();
    chk("bge_npc", f_npc, 5'b00001);
    chk("bge_flush", f_flush, 1);
    ex_lt = 1'b1; #1;
    chk("bge_nt_npc", f_npc, 5'b00000);
    ex_lt = 1'b0;
    drain();

    // jal x1 in EX while ID reads x1: flush wins over the interlock stall.
    issue(32'h010000EF);
    chk("j_ext", f_ext, 6'b000001);
    tick();
    issue(32'h00108133);
    chk("j_npc", f_npc, 5'b00010);
    chk("j_flush", f_flush, 1);
    chk("j_stall", f_stall, 0);
    chk("j_ilk_flush", i_flush, 1);
    chk("j_ilk_stall", i_stall, 0);
    tick(); idle();
    chk("j_squash", f_alu, 0);
    tick();
    chk("j_wb_sel", f_sel, 2'b10);
    chk("j_wb_rd", f_rd, 1);
    chk("j_wb_we", f_we, 1);
    drain();

    // jalr x1,0(x1)
    issue(32'h000080E7);
    tick(); idle();
    chk("jr_npc", f_npc, 5'b00100);
    chk("jr_alu", f_alu, 5'b00011);
    chk("jr_src", f_src, 1);
    chk("jr_flush", f_flush, 1);
    drain();

    // sw x2,0(x1)
    issue(32'h0020A023);
    chk("st_ext", f_ext, 6'b001000);
    tick(); idle();
    chk("st_src", f_src, 1);
    tick();
    chk("st_mem_write", f_mw, 1);
    chk("st_mem_f3", f_f3, 3'b010);
    tick();
    chk("st_wb_we", f_we, 0);
    drain();

    // mul x3,x1,x2
    issue(32'h022081B3);
    tick(); idle();
`ifdef PIPE_CTRL_MULDIV_EN
    chk("mul_alu", f_alu, 5'b10010);
`else
    chk("mul_alu", f_alu, 5'b00000);
`endif
    drain();

    // Reset asserted mid-stall discards the stalled state.
    issue(32'h0000A283);
    tick();
    issue(32'h00528333);
    chk("rs_stall", f_stall, 1);
    rstn = 1'b0; #1;
    chk("rs_stall_rst", f_stall, 0);
    chk("rs_ex_alu", f_alu, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rs_first", f_alu, 5'b00011);
    chk("rs_stall_after", f_stall, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
